// File: rtl/floo_link_fifo.sv
// Elastic link FIFO between adjacent tile routers on one FlooNoC channel, with occupancy and
// high-watermark reporting. Define FLOO_LINK_FIFO_PERF_EN to add the stall_cnt_o backpressure counter.
module floo_link_fifo #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned Depth     = 4,
    parameter int unsigned CntWidth  = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 hwm_clr_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [DataWidth-1:0] data_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [DataWidth-1:0] data_o,
    output logic [CntWidth-1:0]  usage_o,
`ifdef FLOO_LINK_FIFO_PERF_EN
    output logic [31:0]          stall_cnt_o,
`endif
    output logic [CntWidth-1:0]  hwm_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Depth - 1);
    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0]  count_q, count_d;
    logic [CntWidth-1:0]  hwm_q, hwm_d;
    logic                 push, pop;

    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrWidth'(1);
    endfunction

    // Handshake: a transfer happens on a side when valid and ready are both high at the
    // rising edge; ready_o depends only on occupancy and flush, never on ready_i.
    assign ready_o = (count_q != DepthCnt) & ~flush_i;
    assign valid_o = (count_q != '0);
    assign push    = valid_i & ready_o;
    assign pop     = valid_o & ready_i;

    // Gated head read keeps data_o at zero whenever nothing valid is presented.
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign usage_o = count_q;
    assign hwm_o   = hwm_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = next_ptr(wr_ptr_q);
        if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
        case ({push, pop})
            2'b10:   count_d = count_q + CntWidth'(1);
            2'b01:   count_d = count_q - CntWidth'(1);
            default: count_d = count_q;
        endcase
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        // Clearing loads the post-edge count so a level reached in this very cycle is kept.
        if (hwm_clr_i) begin
            hwm_d = count_d;
        end else if (count_d > hwm_q) begin
            hwm_d = count_d;
        end else begin
            hwm_d = hwm_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hwm_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hwm_q    <= hwm_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= data_i;
    end

`ifdef FLOO_LINK_FIFO_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hwm_clr_i) begin
            stall_cnt_d = '0;
        end else if (valid_o && !ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

`ifndef SYNTHESIS
    logic                 hold_chk_q;
    logic [DataWidth-1:0] data_prev_q;

    // A stalled head must not change unless a flush or reset intervenes.
    always_ff @(posedge clk_i) begin
        hold_chk_q  <= ~rst_i & valid_o & ~ready_i & ~flush_i;
        data_prev_q <= data_o;
        if (hold_chk_q && !rst_i) begin
            assert (data_o == data_prev_q) else $error("data_o changed while stalled");
        end
        assert (count_q <= DepthCnt) else $error("entry count above Depth");
    end
`endif

endmodule

// File: tb/tb_floo_link_fifo.sv
// Directed bench for floo_link_fifo: a Depth=4 and a Depth=3 instance driven side by side.
module tb_floo_link_fifo;

    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Depth=4 instance
    logic          rst4 = 1'b1, flush4 = 1'b0, clr4 = 1'b0, valid4 = 1'b0, ready4 = 1'b0;
    logic [DW-1:0] din4 = '0;
    logic          rdy_o4, vld_o4;
    logic [DW-1:0] dout4;
    logic [2:0]    usage4, hwm4;
`ifdef FLOO_LINK_FIFO_PERF_EN
    logic [31:0]   stall4, stall3;
`endif

    // Depth=3 instance
    logic          rst3 = 1'b1, flush3 = 1'b0, clr3 = 1'b0, valid3 = 1'b0, ready3 = 1'b0;
    logic [DW-1:0] din3 = '0;
    logic          rdy_o3, vld_o3;
    logic [DW-1:0] dout3;
    logic [1:0]    usage3, hwm3;

    floo_link_fifo #(.DataWidth(DW), .Depth(4)) u4 (
        .clk_i(clk), .rst_i(rst4), .flush_i(flush4), .hwm_clr_i(clr4),
        .valid_i(valid4), .ready_o(rdy_o4), .data_i(din4),
        .valid_o(vld_o4), .ready_i(ready4), .data_o(dout4),
        .usage_o(usage4),
`ifdef FLOO_LINK_FIFO_PERF_EN
        .stall_cnt_o(stall4),
`endif
        .hwm_o(hwm4)
    );

    floo_link_fifo #(.DataWidth(DW), .Depth(3)) u3 (
        .clk_i(clk), .rst_i(rst3), .flush_i(flush3), .hwm_clr_i(clr3),
        .valid_i(valid3), .ready_o(rdy_o3), .data_i(din3),
        .valid_o(vld_o3), .ready_i(ready3), .data_o(dout3),
        .usage_o(usage3),
`ifdef FLOO_LINK_FIFO_PERF_EN
        .stall_cnt_o(stall3),
`endif
        .hwm_o(hwm3)
    );

    logic [DW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int nxt, pops, cyc;
        logic tog;

        // Reset: two cycles with rst high on both instances
        step(2);
        check("rst_valid", vld_o4, 0);
        check("rst_ready", rdy_o4, 1);
        check("rst_usage", usage4, 0);
        check("rst_hwm", hwm4, 0);
        check("rst_data", dout4, 0);
`ifdef FLOO_LINK_FIFO_PERF_EN
        check("rst_stall", stall4, 0);
`endif
        rst4 = 1'b0;
        rst3 = 1'b0;

        // First push: visible exactly one cycle later
        valid4 = 1'b1; din4 = 16'h00A1;
        check("nofallthru", vld_o4, 0);
        step(1);
        valid4 = 1'b0;
        check("first_valid", vld_o4, 1);
        check("first_data", dout4, 16'h00A1);
        check("first_usage", usage4, 1);
        ready4 = 1'b1;
        step(1);
        ready4 = 1'b0;
        check("first_pop", vld_o4, 0);

        // Fill Depth=4 with downstream stalled
        for (int i = 0; i < 4; i++) begin
            valid4 = 1'b1; din4 = DW'(16'h10 + i);
            step(1);
        end
        check("full_ready", rdy_o4, 0);
        check("full_usage", usage4, 4);
        check("full_hwm", hwm4, 4);
        din4 = 16'h0014;
        step(1);
        valid4 = 1'b0;
        check("held_usage", usage4, 4);
        check("held_head", dout4, 16'h0010);
        ready4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", vld_o4, 1);
            check("drain_data", dout4, DW'(16'h10 + i));
            step(1);
        end
        ready4 = 1'b0;
        check("drain_empty", vld_o4, 0);
        check("drain_hwm", hwm4, 4);

        // Depth=3: push attempted at full while popping
        for (int i = 0; i < 3; i++) begin
            valid3 = 1'b1; din3 = DW'(16'h30 + i);
            step(1);
        end
        check("d3_full_usage", usage3, 3);
        din3 = 16'h0033; ready3 = 1'b1;
        check("d3_full_ready", rdy_o3, 0);
        check("d3_full_head", dout3, 16'h0030);
        step(1);
        check("d3_after_pop_usage", usage3, 2);
        check("d3_after_pop_head", dout3, 16'h0031);
        check("d3_after_pop_ready", rdy_o3, 1);
        ready3 = 1'b0;
        step(1);
        valid3 = 1'b0;
        check("d3_refill_usage", usage3, 3);
        ready3 = 1'b1;
        for (int i = 1; i < 4; i++) begin
            check("d3_drain_data", dout3, DW'(16'h30 + i));
            step(1);
        end
        ready3 = 1'b0;
        check("d3_drain_empty", vld_o3, 0);

        // Wrap-around stream, ready toggling 1,0,1,0
        nxt = 0; pops = 0; cyc = 0; tog = 1'b1;
        while ((nxt < 10 || exp_q.size() != 0) && cyc < 200) begin
            valid3 = (nxt < 10);
            din3   = DW'(nxt);
            ready3 = tog;
            if (vld_o3 && ready3) begin
                if (exp_q.size() == 0) check("wrap_unexpected", 1, 0);
                else check("wrap_data", dout3, exp_q.pop_front());
                pops++;
            end
            if (valid3 && rdy_o3) begin
                exp_q.push_back(DW'(nxt));
                nxt++;
            end
            step(1);
            if (usage3 > 2'd3) check("wrap_usage", usage3, 3);
            tog = ~tog;
            cyc++;
        end
        valid3 = 1'b0; ready3 = 1'b0;
        check("wrap_done", (cyc < 200), 1);
        check("wrap_pops", pops, 10);

        // Flush with 3 stored entries and an incoming flit
        for (int i = 0; i < 3; i++) begin
            valid3 = 1'b1; din3 = DW'(16'h50 + i);
            step(1);
        end
        flush3 = 1'b1; din3 = 16'h0055;
        valid3 = 1'b1;
        check("flush_ready", rdy_o3, 0);
        step(1);
        flush3 = 1'b0; valid3 = 1'b0;
        check("flush_usage", usage3, 0);
        check("flush_valid", vld_o3, 0);
        check("flush_hwm", hwm3, 3);
        clr3 = 1'b1;
        step(1);
        clr3 = 1'b0;
        check("clr_hwm", hwm3, 0);
        valid3 = 1'b1; din3 = 16'h0060;
        step(1);
        valid3 = 1'b0;
        check("post_flush_data", dout3, 16'h0060);
        check("post_flush_hwm", hwm3, 1);

        // Reset mid-operation on Depth=3 with a push attempted in the reset cycle
        valid3 = 1'b1; din3 = 16'h0070;
        step(1);
        rst3 = 1'b1; din3 = 16'h0071;
        step(1);
        rst3 = 1'b0; valid3 = 1'b0;
        check("midrst_valid", vld_o3, 0);
        check("midrst_usage", usage3, 0);
        check("midrst_hwm", hwm3, 0);
        check("midrst_ready", rdy_o3, 1);

        // Depth=4: high-watermark clear loads the post-edge count, stall counting
        valid4 = 1'b1; din4 = 16'h00B0;
        step(1);
        valid4 = 1'b0; clr4 = 1'b1;
        step(1);
        clr4 = 1'b0;
        check("clr_keeps_count", hwm4, 1);
`ifdef FLOO_LINK_FIFO_PERF_EN
        check("stall_cleared", stall4, 0);
`endif
        step(7);
        check("stall_head", dout4, 16'h00B0);
`ifdef FLOO_LINK_FIFO_PERF_EN
        check("stall_seven", stall4, 7);
        clr4 = 1'b1;
        step(1);
        clr4 = 1'b0;
        check("stall_clr", stall4, 0);
        force u4.stall_cnt_q = 32'hFFFF_FFFE;
        step(1);
        release u4.stall_cnt_q;
        step(1);
        check("stall_to_max", stall4, 32'hFFFF_FFFF);
        step(2);
        check("stall_sat", stall4, 32'hFFFF_FFFF);
        flush4 = 1'b1;
        step(1);
        flush4 = 1'b0;
        check("stall_flush_keeps", stall4, 32'hFFFF_FFFF);
`else
        flush4 = 1'b1;
        step(1);
        flush4 = 1'b0;
`endif
        check("end_empty", vld_o4, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
